// File: rtl/env_gen_pkg.sv
// Shared envelope-generator definitions: state word layout, sweep FSM encoding
// and the read-result source selector used by the state RAM.
package env_gen_pkg;

    localparam int unsigned ENV_ST_W       = 4;
    localparam int unsigned ENV_ST_LSB     = 0;
    localparam int unsigned ENV_DIST_W     = 17;
    localparam int unsigned ENV_DIST_LSB   = ENV_ST_LSB + ENV_ST_W;
    localparam int unsigned ENV_OLDLVL_W   = 16;
    localparam int unsigned ENV_OLDLVL_LSB = ENV_DIST_LSB + ENV_DIST_W;
    localparam int unsigned ENV_LEVEL_W    = 16;
    localparam int unsigned ENV_LEVEL_LSB  = ENV_OLDLVL_LSB + ENV_OLDLVL_W;
    localparam int unsigned ENV_STATE_W    = ENV_LEVEL_LSB + ENV_LEVEL_W;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } sweep_state_e;

    typedef enum logic [1:0] {
        SelZero,
        SelRam,
        SelFwd
    } rd_sel_e;

    function automatic logic [ENV_STATE_W-1:0] env_state_pack(
        input logic [ENV_LEVEL_W-1:0]  level,
        input logic [ENV_OLDLVL_W-1:0] oldlevel,
        input logic [ENV_DIST_W-1:0]   distance,
        input logic [ENV_ST_W-1:0]     st
    );
        return {level, oldlevel, distance, st};
    endfunction

endpackage

// File: rtl/env_state_ram_if.sv
// Access bus of the envelope state RAM: write port, read port, sweep control.
interface env_state_ram_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 53
);
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              re;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              clr_req;
    logic              busy;
    logic              addr_err;

    modport master (
        output we, wr_addr, wr_data, re, rd_addr, clr_req,
        input  rd_data, rd_valid, busy, addr_err
    );

    modport slave (
        input  we, wr_addr, wr_data, re, rd_addr, clr_req,
        output rd_data, rd_valid, busy, addr_err
    );
endinterface

// File: rtl/env_state_dpram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module env_state_dpram #(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 53
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/env_state_ram.sv
// Envelope state RAM: write-first forwarding, 1/2-cycle read latency, range checking
// and a zero-fill sweep that owns the write port while busy.
module env_state_ram
    import env_gen_pkg::*;
#(
    parameter int unsigned VOICES        = 32,
    parameter int unsigned V_ENVS        = 16,
    parameter int unsigned DATA_W        = 53,
    parameter int unsigned RD_LAT        = 1,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input logic           clk,
    input logic           reset_reg_N,
    env_state_ram_if.slave bus
);
    localparam int unsigned DEPTH  = VOICES * V_ENVS;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    sweep_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy;

    logic              rd_acc, wr_acc, rd_in_rng, wr_in_rng;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata, ram_rdata;

    rd_sel_e           sel_d, s1_sel_q;
    logic [DATA_W-1:0] s1_fwd_q, s1_data;
    logic              s1_valid_q, addr_err_q;

    assign busy      = (state_q == StClear);
    assign rd_acc    = bus.re & ~busy;
    assign wr_acc    = bus.we & ~busy;
    assign rd_in_rng = ({1'b0, bus.rd_addr} < DEPTH_L);
    assign wr_in_rng = ({1'b0, bus.wr_addr} < DEPTH_L);

    // The sweep takes the write port outright while it runs.
    assign mem_we    = busy | (wr_acc & wr_in_rng);
    assign mem_waddr = busy ? cnt_q : bus.wr_addr;
    assign mem_wdata = busy ? '0 : bus.wr_data;

    env_state_dpram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dpram (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (rd_acc & rd_in_rng),
        .raddr_i (bus.rd_addr),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (bus.clr_req) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q <= INIT_ON_RESET ? StClear : StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        sel_d = SelRam;
        if (!rd_in_rng) begin
            sel_d = SelZero;
        end else if (mem_we && (mem_waddr == bus.rd_addr)) begin
            sel_d = SelFwd;
        end
    end

    // Selector and forwarded word only move on an accepted read, so the result holds.
    always_ff @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            s1_valid_q <= 1'b0;
            s1_sel_q   <= SelZero;
            s1_fwd_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_acc;
            addr_err_q <= (rd_acc & ~rd_in_rng) | (wr_acc & ~wr_in_rng);
            if (rd_acc) begin
                s1_sel_q <= sel_d;
                s1_fwd_q <= mem_wdata;
            end
        end
    end

    always_comb begin
        s1_data = '0;
        case (s1_sel_q)
            SelRam:  s1_data = ram_rdata;
            SelFwd:  s1_data = s1_fwd_q;
            default: s1_data = '0;
        endcase
    end

    assign bus.busy     = busy;
    assign bus.addr_err = addr_err_q;

    if (RD_LAT == 1) begin : g_lat1
        assign bus.rd_data  = s1_data;
        assign bus.rd_valid = s1_valid_q;
    end else begin : g_lat2
        logic [ADDR_W-1:0] s1_addr_q;
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        // A write landing one cycle after the read still reaches that read's result.
        always_ff @(posedge clk or negedge reset_reg_N) begin
            if (!reset_reg_N) begin
                s1_addr_q  <= '0;
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                if (rd_acc) begin
                    s1_addr_q <= bus.rd_addr;
                end
                rd_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    rd_data_q <= (mem_we && (mem_waddr == s1_addr_q) && (s1_sel_q != SelZero))
                                 ? mem_wdata : s1_data;
                end
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end
endmodule

// File: tb/tb_env_state_ram.sv
// Bench for env_state_ram: three instances (latency 1, latency 2, non-power-of-two depth)
// share one stimulus stream and are compared every cycle against a memory-level model.
module tb_env_state_ram;
    localparam int unsigned NK = 3;
    localparam int unsigned DEPTHS [NK] = '{512, 512, 320};
    localparam int unsigned LATS   [NK] = '{1, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, re, clr_req;
    logic [8:0]  wr_addr, rd_addr;
    logic [52:0] wr_data;

    logic [52:0] d_rd_data [NK];
    logic        d_rd_valid [NK];
    logic        d_busy [NK];
    logic        d_err [NK];

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    env_state_ram_if #(.ADDR_W(9), .DATA_W(53)) sif [NK] ();

    for (genvar k = 0; k < NK; k++) begin : g_bus
        assign sif[k].we      = we;
        assign sif[k].wr_addr = wr_addr;
        assign sif[k].wr_data = wr_data;
        assign sif[k].re      = re;
        assign sif[k].rd_addr = rd_addr;
        assign sif[k].clr_req = clr_req;
        assign d_rd_data[k]   = sif[k].rd_data;
        assign d_rd_valid[k]  = sif[k].rd_valid;
        assign d_busy[k]      = sif[k].busy;
        assign d_err[k]       = sif[k].addr_err;
    end

    env_state_ram #(.RD_LAT(1)) dut_a (.clk(clk), .reset_reg_N(rst_n), .bus(sif[0]));
    env_state_ram #(.RD_LAT(2)) dut_b (.clk(clk), .reset_reg_N(rst_n), .bus(sif[1]));
    env_state_ram #(.VOICES(20), .RD_LAT(1)) dut_c (.clk(clk), .reset_reg_N(rst_n),
                                                    .bus(sif[2]));

    // Model state
    logic [52:0] m_mem [NK][512];
    logic        m_busy [NK];
    int unsigned m_cnt [NK];
    logic [52:0] m_rd_data [NK];
    logic        m_rd_valid [NK];
    logic        m_err [NK];
    logic        m_pend [NK];
    int unsigned m_pend_addr [NK];

    task automatic check(input string name, input logic [52:0] act, input logic [52:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic deliver(input int k, input int unsigned a);
        m_rd_valid[k] = 1'b1;
        m_rd_data[k]  = (a < DEPTHS[k]) ? m_mem[k][a] : '0;
    endtask

    task automatic model_step(input int k);
        bit          rd_acc, wr_acc;
        int unsigned ra, wa;
        ra     = rd_addr;
        wa     = wr_addr;
        rd_acc = re && !m_busy[k];
        wr_acc = we && !m_busy[k];
        m_rd_valid[k] = 1'b0;
        m_err[k] = (rd_acc && ra >= DEPTHS[k]) || (wr_acc && wa >= DEPTHS[k]);
        if (m_busy[k]) m_mem[k][m_cnt[k]] = '0;
        else if (wr_acc && wa < DEPTHS[k]) m_mem[k][wa] = wr_data;
        // A read returns memory as it stands after the writes of its last open cycle.
        if (LATS[k] == 2) begin
            if (m_pend[k]) deliver(k, m_pend_addr[k]);
            m_pend[k]      = rd_acc;
            m_pend_addr[k] = ra;
        end else if (rd_acc) begin
            deliver(k, ra);
        end
        if (clr_req) begin
            m_busy[k] = 1'b1;
            m_cnt[k]  = 0;
        end else if (m_busy[k]) begin
            if (m_cnt[k] == DEPTHS[k] - 1) m_busy[k] = 1'b0;
            else m_cnt[k]++;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NK; k++) begin
            if (!rst_n) begin
                m_busy[k]     = 1'b1;
                m_cnt[k]      = 0;
                m_rd_data[k]  = '0;
                m_rd_valid[k] = 1'b0;
                m_err[k]      = 1'b0;
                m_pend[k]     = 1'b0;
            end else begin
                model_step(k);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < NK; k++) begin
                check($sformatf("dut%0d busy", k), 53'(d_busy[k]), 53'(m_busy[k]));
                check($sformatf("dut%0d rd_valid", k), 53'(d_rd_valid[k]), 53'(m_rd_valid[k]));
                check($sformatf("dut%0d addr_err", k), 53'(d_err[k]), 53'(m_err[k]));
                check($sformatf("dut%0d rd_data", k), d_rd_data[k], m_rd_data[k]);
            end
        end
    end

    task automatic cyc(input bit w, input int wa, input logic [52:0] wd,
                       input bit r, input int ra, input bit c);
        @(negedge clk);
        we      = w;
        wr_addr = 9'(wa);
        wr_data = wd;
        re      = r;
        rd_addr = 9'(ra);
        clr_req = c;
    endtask

    task automatic idle();
        cyc(1'b0, 0, '0, 1'b0, 0, 1'b0);
    endtask

    // Counts cycles dut_a reports busy, optionally hammering address 37 meanwhile.
    task automatic count_busy(input bit junk, output int n);
        n = 0;
        while (d_busy[0] && n < 2000) begin
            n++;
            we      = junk;
            wr_addr = 9'd37;
            wr_data = 53'hDEAD;
            re      = junk;
            rd_addr = 9'd37;
            clr_req = 1'b0;
            @(negedge clk);
        end
        we = 1'b0;
        re = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        we = 1'b0; re = 1'b0; clr_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            check($sformatf("reset dut%0d rd_data", k), d_rd_data[k], '0);
            check($sformatf("reset dut%0d rd_valid", k), 53'(d_rd_valid[k]), '0);
            check($sformatf("reset dut%0d addr_err", k), 53'(d_err[k]), '0);
            check($sformatf("reset dut%0d busy", k), 53'(d_busy[k]), 53'd1);
        end

        // Power-up sweep length, then a cleared word at the top address
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(1'b0, n);
        check("init sweep cycles", 53'(n), 53'd512);
        cyc(1'b0, 0, '0, 1'b1, 511, 1'b0);
        idle();
        check("addr 511 cleared", d_rd_data[0], '0);
        check("addr 511 valid", 53'(d_rd_valid[0]), 53'd1);

        // Write then read, latency 1; result then holds
        cyc(1'b1, 37, 53'h1_2345_6789_ABCD, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 37, 1'b0);
        idle();
        check("rd 37 data", d_rd_data[0], 53'h1_2345_6789_ABCD);
        check("rd 37 valid", 53'(d_rd_valid[0]), 53'd1);
        idle();
        check("rd 37 hold", d_rd_data[0], 53'h1_2345_6789_ABCD);
        check("rd 37 valid drop", 53'(d_rd_valid[0]), '0);

        // Same-cycle write/read forwarding
        cyc(1'b1, 5, 53'h33, 1'b0, 0, 1'b0);
        cyc(1'b1, 5, 53'hFF, 1'b1, 5, 1'b0);
        idle();
        check("fwd same cycle lat1", d_rd_data[0], 53'hFF);

        // Latency 2: write in the cycle after the read still forwards
        cyc(1'b1, 5, 53'h33, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 5, 1'b0);
        cyc(1'b1, 5, 53'hFF, 1'b0, 0, 1'b0);
        check("lat1 no late fwd", d_rd_data[0], 53'h33);
        idle();
        check("fwd next cycle lat2", d_rd_data[1], 53'hFF);
        check("fwd next cycle lat2 valid", 53'(d_rd_valid[1]), 53'd1);

        // Out-of-range access on the 320-deep instance
        cyc(1'b1, 80, 53'h5A, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 400, 1'b0);
        idle();
        check("oor rd data", d_rd_data[2], '0);
        check("oor rd valid", 53'(d_rd_valid[2]), 53'd1);
        check("oor rd err", 53'(d_err[2]), 53'd1);
        idle();
        check("oor err one pulse", 53'(d_err[2]), '0);
        cyc(1'b1, 400, 53'h77, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 80, 1'b0);
        check("oor wr err", 53'(d_err[2]), 53'd1);
        idle();
        check("oor wr dropped", d_rd_data[2], 53'h5A);
        cyc(1'b0, 0, '0, 1'b1, 400, 1'b0);
        idle();
        check("in-range 400 on 512", d_rd_data[0], 53'h77);

        // Reset pulse in the middle of a sweep
        cyc(1'b0, 0, '0, 1'b0, 0, 1'b1);
        repeat (50) idle();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("async rst dut%0d rd_data", k), d_rd_data[k], '0);
            check($sformatf("async rst dut%0d busy", k), 53'(d_busy[k]), 53'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(1'b0, n);
        check("sweep after reset", 53'(n), 53'd512);

        // Read accepted with clr_req completes; clr_req at cnt=100 restarts the sweep
        cyc(1'b1, 80, 53'h5A, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 80, 1'b1);
        idle();
        check("pending rd lat1", d_rd_data[0], 53'h5A);
        check("busy after clr", 53'(d_busy[0]), 53'd1);
        idle();
        check("pending rd lat2", d_rd_data[1], 53'h5A);
        check("pending rd lat2 valid", 53'(d_rd_valid[1]), 53'd1);
        repeat (98) idle();
        cyc(1'b0, 0, '0, 1'b0, 0, 1'b1);
        idle();
        count_busy(1'b1, n);
        check("restart sweep cycles", 53'(n), 53'd512);
        cyc(1'b0, 0, '0, 1'b1, 37, 1'b0);
        idle();
        check("no write while busy", d_rd_data[0], '0);
        repeat (3) idle();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
